// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and buffers {pc+4, inst} words.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap to EXC_VECTOR and pulse misalign.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] pcOut,
    output logic [31:0] instOut,
    output logic        validOut,
    output logic        misalign
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t           r_state;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_pc;
    logic [31:0]      r_buf_pc   [BUF_DEPTH];
    logic [31:0]      r_buf_inst [BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_outstanding;
    logic [CNT_W-1:0] w_inflight;
    logic             w_issue;
    logic             w_accept;
    logic             w_push;
    logic             w_valid;
    logic             w_pop;
    logic [31:0]      w_target;

    // Reserving a slot for the in-flight word means a stalled, full FIFO can never overflow.
    assign w_outstanding = (r_state != S_IDLE);
    assign w_inflight    = r_count + CNT_W'(w_outstanding);
    assign w_issue       = !rst && !redirect && (r_state == S_IDLE) && (w_inflight < DEPTH_C);
    assign w_accept      = w_issue && imemReady;
    assign w_push        = !rst && !redirect && (r_state == S_WAIT) && imemValid;
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && !stall && !redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned = (redirectPc[1:0] != 2'b00);
    assign w_target     = w_misaligned ? EXC_VECTOR : redirectPc;
    assign misalign     = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect && w_misaligned;
        end
    end
`else
    assign w_target = redirectPc & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    assign imemReq  = w_issue;
    assign imemAddr = r_fetch_pc;
    assign validOut = w_valid;
    assign pcOut    = w_valid ? r_buf_pc[r_rd_ptr]   : 32'd0;
    assign instOut  = w_valid ? r_buf_inst[r_rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_req_pc + 32'd4;
            r_buf_inst[r_wr_ptr] <= imemData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // A response landing in the redirect cycle closes the transaction; otherwise it must be dropped later.
            r_state    <= (w_outstanding && !imemValid) ? S_DROP : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imemValid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with random latency, stream model of expected pops, scoreboard monitor.
// Expectations follow FETCH_MISALIGN_TRAP_EN when it is defined for the build.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam int          BUF_DEPTH  = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;
    logic [31:0] pcOut;
    logic [31:0] instOut;
    logic        validOut;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemValid  (imemValid),
        .imemData   (imemData),
        .pcOut      (pcOut),
        .instOut    (instOut),
        .validOut   (validOut),
        .misalign   (misalign)
    );

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    // Expected pop stream: consecutive words from the last reset/redirect target; memory returns addr as data.
    ent_t        exp_q[$];
    logic [31:0] exp_next;
    int          checks = 0;
    int          errors = 0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_lat = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          exp_mis = 1'b0;
    bit          mis_pending = 1'b0;
    bit          mon_en = 1'b0;
    bit          last_acc = 1'b0;

    function automatic bit is_mis(input logic [31:0] p);
        return TRAP_EN && (p[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] target(input logic [31:0] p);
        return is_mis(p) ? EXC_VECTOR : (p & 32'hFFFF_FFFC);
    endfunction

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{pc4: exp_next + 32'd4, inst: exp_next});
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        exp_next = a;
        refill();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within the cycle bound, expected one", name);
    endtask

    // One clock cycle: drive at negedge, observe and update the memory model 1 time unit before posedge.
    task automatic cycle(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                         input bit rdy, input bit stale);
        @(negedge clk);
        rst        = r;
        stall      = st;
        redirect   = rd;
        redirectPc = rpc;
        imemReady  = rdy;
        exp_mis     = mis_pending;
        mis_pending = !r && rd && is_mis(rpc);
        if (mem_busy && mem_lat == 0) begin
            imemValid = 1'b1;
            imemData  = mem_addr;
        end else begin
            imemValid = stale;
            imemData  = stale ? 32'hDEAD_BEEF : $urandom;
            if (mem_busy) mem_lat--;
        end
        if (r) restart(RESET_PC);
        else if (rd) restart(target(rpc));
        #4;
        if (!r && mem_busy) check("req_while_outstanding", imemReq, 1'b0);
        if (imemValid || r) mem_busy = 1'b0;
        last_acc = !r && imemReq && imemReady;
        if (last_acc) begin
            mem_busy = 1'b1;
            mem_addr = imemAddr;
            mem_lat  = $urandom_range(lat_max, lat_min);
        end
    endtask

    task automatic wait_accept(input string name);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            if (last_acc) return;
        end
        timeout(name);
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] exp_pc4);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            if (validOut) begin
                check(name, pcOut, exp_pc4);
                return;
            end
        end
        timeout(name);
    endtask

    task automatic redirect_follow(input string name, input bit st, input logic [31:0] rpc);
        logic [31:0] t;
        bit found;
        t = target(rpc);
        found = 1'b0;
        cycle(1'b0, st, 1'b1, rpc, 1'b1, 1'b0);
        check({name, "_req_suppressed"}, imemReq, 1'b0);
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            if (i == 0) begin
                check({name, "_flush"}, validOut, 1'b0);
                check({name, "_misalign"}, misalign, is_mis(rpc));
            end
            if (imemReq) begin
                check({name, "_addr"}, imemAddr, t);
                found = 1'b1;
            end
        end
        if (!found) timeout({name, "_req"});
        wait_valid_pc({name, "_first_pc"}, t + 32'd4);
    endtask

    // Scoreboard monitor: every pop is compared with the front of the expected stream.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                check("misalign", 32'(misalign), 32'(exp_mis));
                if (!rst) begin
                    if (validOut) begin
                        if (!stall && !redirect) begin
                            check("pop_pc", pcOut, exp_q[0].pc4);
                            check("pop_inst", instOut, exp_q[0].inst);
                            $display("pop pc=%h inst=%h", pcOut, instOut);
                            void'(exp_q.pop_front());
                            refill();
                        end
                    end else begin
                        check("nop_pc", pcOut, 32'd0);
                        check("nop_inst", instOut, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        int first;
        logic [31:0] rv;
        logic [31:0] rpc;
        bit r;
        bit rd;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
        imemReady = 1'b0; imemValid = 1'b0; imemData = '0;
        restart(RESET_PC);

        // Reset state and zero-wait start-up latency.
        lat_min = 0; lat_max = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        mon_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("reset_req", imemReq, 1'b0);
        check("reset_valid", validOut, 1'b0);
        check("reset_pc", pcOut, 32'd0);
        check("reset_inst", instOut, 32'd0);
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            if (i == 1) begin
                check("first_req", imemReq, 1'b1);
                check("first_addr", imemAddr, RESET_PC);
            end
            if (validOut && first < 0) first = i;
        end
        check("first_valid_cycle", first, 3);

        // Long stall: head frozen, FIFO fills, requests stop; release pops twice back to back.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
            if (i >= 4) begin
                check("stall_valid", validOut, 1'b1);
                check("stall_head", pcOut, exp_q[0].pc4);
                check("stall_no_req", imemReq, 1'b0);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("release_pop1", validOut, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("release_pop2", validOut, 1'b1);

        // Redirect together with stall on a full FIFO.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        check("full_before_redirect", validOut, 1'b1);
        redirect_follow("redir_stall_full", 1'b1, 32'h0000_0200);

        // Redirect while a request is in flight: stale word must be dropped.
        lat_min = 2; lat_max = 2;
        wait_accept("wait_accept_redir");
        redirect_follow("redir_wait", 1'b0, 32'h0000_0100);

        // Misaligned target and PC wrap-around.
        lat_min = 0; lat_max = 1;
        redirect_follow("redir_misalign", 1'b0, 32'h0000_0102);
        redirect_follow("redir_wrap", 1'b0, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Reset mid-transaction, stale response arrives the cycle after release.
        lat_min = 2; lat_max = 2;
        wait_accept("wait_accept_rst");
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check("post_rst_req", imemReq, 1'b1);
        check("post_rst_addr", imemAddr, RESET_PC);
        wait_valid_pc("post_rst_first_pc", RESET_PC + 32'd4);

        // Randomized traffic.
        lat_min = 0; lat_max = 3;
        for (int n = 0; n < 3000; n++) begin
            rv = $urandom;
            case ($urandom % 4)
                0:       rpc = rv;
                1:       rpc = 32'hFFFF_FFF8;
                default: rpc = rv & 32'h0000_FFFC;
            endcase
            r  = ($urandom % 300) == 0;
            rd = !r && (($urandom % 16) == 0);
            cycle(r, ($urandom % 4) == 0, rd, rpc, ($urandom % 4) != 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the mips32 pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter, issues requests to instruction memory through a req/ready/valid handshake, and buffers returned words in a small FIFO. It presents one {PC+4, instruction} pair per cycle to IF/ID and honours hazard stalls and branch/jump redirects from later stages.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- BUF_DEPTH, 2, fetch FIFO entries; power of two, ≥2
- EXC_VECTOR, 32'h8000_0180, target taken on misaligned redirect (only with FETCH_MISALIGN_TRAP_EN)

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold current output, no pop
- redirect  in  1  branch/jump taken; flush and refetch
- redirectPc  in  32  new fetch address, sampled when redirect=1
- imemReq  out  1  request valid
- imemAddr  out  32  request address (word-aligned fetch PC)
- imemReady  in  1  memory accepts request this cycle when imemReq=1
- imemValid  in  1  returned word valid this cycle
- imemData  in  32  returned instruction word
- pcOut  out  32  fetch PC + 4 of the presented instruction, to IF/ID pcIn
- instOut  out  32  presented instruction, to IF/ID instIn; 0 (NOP) when no valid entry
- validOut  out  1  pcOut/instOut hold a real instruction
- misalign  out  1  one-cycle pulse: redirect target was not word-aligned

## Operation
- Internal state: fetchPc, FIFO (BUF_DEPTH entries of {pc+4, inst}), count, outstanding flag (max one in-flight request), FSM.
- FSM states: IDLE (no request in flight), WAIT (request accepted, awaiting imemValid), DROP (in-flight response must be discarded).
- IDLE: imemReq=1 when count + outstanding < BUF_DEPTH; on imemReady, capture request PC, fetchPc += 4, go WAIT.
- WAIT: imemReq=0; on imemValid push {reqPc+4, imemData}, go IDLE (may issue a new request the same cycle it returns).
- DROP: imemReq=0; on imemValid discard word, go IDLE.
- Output: FIFO head when count>0 (validOut=1); otherwise pcOut=0, instOut=0, validOut=0.
- Pop: validOut=1 and stall=0 and redirect=0.
- Redirect (priority over stall, pop, push): FIFO emptied, fetchPc ← redirectPc, state WAIT→DROP, DROP stays DROP, IDLE stays IDLE; request issue suppressed that cycle.
- imemValid in IDLE: ignored.
- Arithmetic: PC adds modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).

## Timing
- Reset cycle: fetchPc=RESET_PC, FIFO empty, state IDLE, imemReq=0, pcOut=0, instOut=0, validOut=0, misalign=0.
- First cycle after rst deasserts: imemReq=1, imemAddr=RESET_PC.
- FIFO write is registered: word returned with imemValid in cycle N appears on outputs in cycle N+1. Zero-wait memory (ready at N, valid at N+1) → validOut at N+2.
- Full FIFO with stall: outputs constant; no request issued (count + outstanding = BUF_DEPTH), so overflow cannot occur.
- Simultaneous push and pop: count unchanged, head advances.
- Redirect in cycle N: outputs NOP/validOut=0 from N+1; first request to redirectPc issued N+1 (IDLE) or after the discarded response (DROP).
- rst asserted mid-transaction: all state returns to reset values; pending response after reset is ignored (state IDLE).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirectPc[1:0]≠0 loads fetchPc=EXC_VECTOR and pulses misalign for the cycle after the redirect.
- Undefined: redirectPc[1:0] forced to 0; misalign tied 0.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr-as-data → validOut first at cycle 3 after reset release; pcOut sequence 4, 8, 12; instOut 0, 4, 8.
- stall held 5 cycles with BUF_DEPTH=2 → outputs frozen, at most 2 buffered, imemReq low; release → 2 consecutive pops without bubble.
- redirect to 0x0000_0100 while WAIT → stale return discarded, next imemAddr=0x100, next valid pcOut=0x104.
- redirect and stall asserted together with full FIFO → FIFO flushed, validOut=0 next cycle, fetch resumes at redirectPc.
- redirect to 0x0000_0102: with FETCH_MISALIGN_TRAP_EN → misalign=1, imemAddr=0x8000_0180; without → imemAddr=0x100, misalign=0.
- rst asserted while WAIT, imemValid arrives the cycle after → word ignored, refetch from RESET_PC.
